mem_stage_lsu: RTL
==================

# mem_stage_lsu

Parametrised memory stage for the pipelined CPU. It sits between execute and writeback and replaces the fixed single-cycle store path with a valid/ready request port to data memory of arbitrary latency. Loads and stores are handled, and the upstream pipeline is stalled while an access is outstanding. It keeps the existing bubble, halt-detection and halt-suppression semantics.

## Interface
Parameters:
- `INSTR_W`, default 16: instruction width; opcode fields are `instr[15:12]` (high) and `instr[7:4]` (low).
- `DATA_W`, default 16: data and result width.
- `ADDR_W`, default 16: memory address width; the address is `result_in[ADDR_W-1:0]`.

Ports:
- `clk` in 1: clock. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous active-low reset.
- `bubble_in` in 1: the input slot is empty.
- `halt_in_wb` in 1: writeback holds a halt; squash new work.
- `instr_in` in INSTR_W: instruction from execute.
- `result_in` in DATA_W: ALU result, or the address for a load/store.
- `store_data_in` in DATA_W: store data.
- `stall_out` out 1: upstream must hold all inputs this cycle.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: 1 = store, 0 = load.
- `mem_addr` out ADDR_W: request address.
- `mem_wdata` out DATA_W: store data.
- `mem_ready` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: load data valid.
- `mem_rdata` in DATA_W: load data.
- `instr_out` out INSTR_W: registered instruction to writeback.
- `result_out` out DATA_W: registered result to writeback.
- `bubble_out` out 1: the writeback slot is empty.
- `halt_in_mem` out 1: combinational; a non-bubble, unrecognised instruction is present.

## Operation
- Decode:
  - store = high opcode F, low opcode 1.
  - load = high opcode F, low opcode 0.
  - known = high opcode ∈ {0, 8, 9}, or (high opcode ∈ {E, F} and low opcode < 4).
- `halt_in_mem` = `!bubble_in && !known`.
- `mem_op` = `!bubble_in && !halt_in_wb && (load || store)`.
- States:
  - **IDLE**:
    - `mem_req` = `mem_op`.
    - Store with `mem_ready`: completes in this cycle.
    - Store or load without `mem_ready`: go to REQ.
    - Load with `mem_ready`: go to WAIT.
  - **REQ**:
    - `mem_req` held at 1 with stable `mem_we`, `mem_addr` and `mem_wdata`. It is never dropped before `mem_ready`, even if `halt_in_wb` rises.
    - On `mem_ready`: a store returns to IDLE with completion; a load goes to WAIT.
  - **WAIT**:
    - `mem_req` = 0.
    - On `mem_rvalid`: capture `mem_rdata` and return to IDLE.
- Request fields come combinationally from the inputs, which upstream holds stable under `stall_out`:
  - `mem_addr` = `result_in[ADDR_W-1:0]`.
  - `mem_wdata` = `store_data_in`.
  - `mem_we` = store.
- `stall_out`:
  - IDLE: `mem_op && !(store && mem_ready)`.
  - REQ: `!(store && mem_ready)`.
  - WAIT: `!mem_rvalid`.
- Output register, per cycle:
  - Completion cycle (non-memory op, accepted store, or `rvalid` load): `instr_out` <= `instr_in`. `result_out` <= `mem_rdata` for a load, otherwise `result_in`. `bubble_out` <= `halt_in_wb | bubble_in`.
  - Any stalled cycle: `bubble_out` <= 1, and `instr_out`/`result_out` hold.
- Halt during WAIT:
  - The load response is still consumed and the state returns to IDLE.
  - `bubble_out` <= 1, so the result is dropped.
- `mem_rvalid` outside WAIT is ignored.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - state=IDLE, `bubble_out`=1, `instr_out`=0, `result_out`=0.
  - Combinational outputs are gated by state=IDLE.
  - A reset during REQ or WAIT abandons the access. Memory must also be reset.
- Latency from input to registered output:
  - Non-memory op: 1 cycle.
  - Store: 1 + (cycles waiting for ready).
  - Load: ≥2 cycles (accept edge, then the `rvalid` edge).
- Zero-wait memory (`ready`=1 in the request cycle, `rvalid` the next cycle):
  - Store: no stall.
  - Load: 1 stall cycle.
- Back-to-back loads: a new request can be issued in the IDLE cycle immediately after the `rvalid` completion. At most one access is outstanding.

## Structure
- Shared package `pipe_pkg` holds:
  - Opcode constants: `OP_MEM`=4'hF, `OP_ALU_E`=4'hE, `SUB_LOAD`=0, `SUB_STORE`=1.
  - Functions `is_load`, `is_store`, `is_known(instr)`.
  - State enum `lsu_state_t` {IDLE, REQ, WAIT}.
- No sub-module: a single FSM plus the output register.

## Test plan
- Non-memory op `instr`=16'h0123, `result`=16'h00AA, `bubble_in`=0 → next cycle `instr_out`=0123, `result_out`=00AA, `bubble_out`=0; `stall_out` never asserted.
- Store `instr`=16'hF010, `addr`=16'h0040, `data`=16'hBEEF, `mem_ready` low for 2 cycles → `mem_req` held for 3 cycles with stable fields; `stall_out`=1 for 2 cycles with `bubble_out`=1; completion cycle after.
- Load `instr`=16'hF000, `addr`=16'h0010, `ready`=1, `rvalid` 3 cycles later with `rdata`=16'h1234 → `stall_out`=1 for 3 cycles; then `result_out`=1234, `bubble_out`=0.
- `halt_in_wb`=1 rising during WAIT → the response is consumed, `bubble_out`=1, state returns to IDLE; a store presented with `halt_in_wb`=1 gives `mem_req`=0.
- Unknown instruction `instr`=16'hA000, `bubble_in`=0 → `halt_in_mem`=1; with `bubble_in`=1 → 0; `instr`=16'hE050 → 1.
- `rst_n` low during WAIT → state IDLE, `bubble_out`=1, `mem_req`=0, `stall_out`=0; a late `rvalid` is ignored.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline opcode constants, decode helpers and LSU state type
package pipe_pkg;

  localparam logic [3:0] OP_MEM    = 4'hF;
  localparam logic [3:0] OP_ALU_E  = 4'hE;
  localparam logic [3:0] SUB_LOAD  = 4'h0;
  localparam logic [3:0] SUB_STORE = 4'h1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // Opcode fields live in instr[15:12] (high) and instr[7:4] (low).
  function automatic logic is_load(input logic [15:0] instr);
    return (instr[15:12] == OP_MEM) && (instr[7:4] == SUB_LOAD);
  endfunction

  function automatic logic is_store(input logic [15:0] instr);
    return (instr[15:12] == OP_MEM) && (instr[7:4] == SUB_STORE);
  endfunction

  function automatic logic is_known(input logic [15:0] instr);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = instr[15:12];
    lo = instr[7:4];
    return (hi == 4'h0) || (hi == 4'h8) || (hi == 4'h9) ||
           (((hi == OP_ALU_E) || (hi == OP_MEM)) && (lo < 4'h4));
  endfunction

endpackage

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory stage with valid/ready data-memory port and upstream stall
module mem_stage_lsu
  import pipe_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bubble_in,
  input  logic               halt_in_wb,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [DATA_W-1:0]  result_in,
  input  logic [DATA_W-1:0]  store_data_in,
  output logic               stall_out,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [DATA_W-1:0]  result_out,
  output logic               bubble_out,
  output logic               halt_in_mem
);

  lsu_state_t state, state_nxt;

  logic ld;
  logic st;
  logic mem_op;
  logic complete;
  logic from_mem;

  assign ld          = is_load(instr_in[15:0]);
  assign st          = is_store(instr_in[15:0]);
  assign halt_in_mem = !bubble_in && !is_known(instr_in[15:0]);
  assign mem_op      = !bubble_in && !halt_in_wb && (ld || st);

  // Request fields follow the held inputs; only the valid depends on state.
  assign mem_addr  = result_in[ADDR_W-1:0];
  assign mem_wdata = store_data_in;
  assign mem_we    = st;

  // FSM next state, request valid, stall and completion decode.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    stall_out = 1'b0;
    complete  = 1'b0;
    from_mem  = 1'b0;
    unique case (state)
      IDLE: begin
        mem_req   = mem_op;
        stall_out = mem_op && !(st && mem_ready);
        complete  = !stall_out;
        if (mem_op && !mem_ready)     state_nxt = REQ;
        else if (mem_op && ld)        state_nxt = WAIT;
      end
      REQ: begin
        // Once issued the request is held until accepted, even under a halt.
        mem_req   = 1'b1;
        stall_out = !(st && mem_ready);
        complete  = !stall_out;
        if (mem_ready) state_nxt = st ? IDLE : WAIT;
      end
      WAIT: begin
        stall_out = !mem_rvalid;
        complete  = mem_rvalid;
        from_mem  = 1'b1;
        if (mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Writeback register: load on completion, insert a bubble while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_out  <= '0;
      result_out <= '0;
      bubble_out <= 1'b1;
    end else if (complete) begin
      instr_out  <= instr_in;
      result_out <= from_mem ? mem_rdata : result_in;
      bubble_out <= halt_in_wb | bubble_in;
    end else begin
      bubble_out <= 1'b1;
    end
  end

endmodule
